// File: rtl/seven_seg_monitor.sv
// ---------------------------------------------------------------------------
// seven_seg_monitor
//
// Receive side of a 4-digit multiplexed 7-segment display bus. The digit
// enables and the shared segment bus are registered, must hold steady for
// SETTLE sampled cycles, and are then decoded back to a hex nibble that is
// latched for the enabled digit. A small tracker checks that digits arrive
// in the order 1,2,3,4 and reports a completed frame; protocol problems
// (multiple enables, out-of-order digit, illegal glyph) raise an error pulse
// and bump a saturating error counter.
//
// Ports
//   CLK      in   1   clock, everything on the rising edge
//   RST      in   1   synchronous active-high reset
//   D1..D4   in   1   digit enables, active-high
//   SEG      in   7   segment bus, SEG[0]=a .. SEG[6]=g
//   VAL      out  16  latched nibbles, VAL[3:0]=digit1 .. VAL[15:12]=digit4
//   VALID    out  4   per digit: last capture was a legal hex glyph
//   FRAME    out  1   one-cycle pulse when digit 4 completes an in-order frame
//   ERR      out  1   one-cycle pulse on any protocol error
//   ERR_CNT  out  8   error count, saturating at 255
// ---------------------------------------------------------------------------
module seven_seg_monitor #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D1,
    input  logic        D2,
    input  logic        D3,
    input  logic        D4,
    input  logic [6:0]  SEG,
    output logic [15:0] VAL,
    output logic [3:0]  VALID,
    output logic        FRAME,
    output logic        ERR,
    output logic [7:0]  ERR_CNT
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        EXP_D1 = 2'd0,
        EXP_D2 = 2'd1,
        EXP_D3 = 2'd2,
        EXP_D4 = 2'd3
    } exp_state_t;

    // Returns {legal, nibble}; unknown patterns decode to nibble 0, illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [10:0] s_q, s_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        captured_q, captured_d;
    logic [15:0] val_q, val_d;
    logic [3:0]  valid_q, valid_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    exp_state_t  exp_q, exp_d;

    logic [3:0]  en;
    logic        is_blank, is_onehot, is_multi;
    logic        qualify, cap, multi_err, seq_err;
    logic [1:0]  idx;
    logic [4:0]  dec;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_q        <= '0;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            val_q      <= '0;
            valid_q    <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            exp_q      <= EXP_D1;
        end else begin
            s_q        <= s_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            val_q      <= val_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            exp_q      <= exp_d;
        end
    end

    always_comb begin
        s_d        = {D4, D3, D2, D1, SEG};
        cnt_d      = cnt_q;
        captured_d = captured_q;
        val_d      = val_q;
        valid_d    = valid_q;
        frame_d    = 1'b0;
        seq_err    = 1'b0;
        exp_d      = exp_q;
        idx        = 2'd0;

        // Classify the held enables; decisions act on the registered sample.
        en        = s_q[10:7];
        is_blank  = (en == 4'b0000);
        is_onehot = !is_blank && ((en & (en - 4'd1)) == 4'b0000);
        is_multi  = !is_blank && !is_onehot;
        dec       = seg_decode(s_q[6:0]);

        case (en)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase

        // One qualification per stable period; captured_q blocks repeats.
        qualify   = (cnt_q == SETTLE_C) && !captured_q;
        cap       = qualify && is_onehot;
        multi_err = qualify && is_multi;

        // A changed sample starts a new stable period and overrides any
        // capture flag set on the same edge.
        if (s_d != s_q) begin
            cnt_d      = 4'd1;
            captured_d = 1'b0;
        end else begin
            if (cnt_q < SETTLE_C) cnt_d = cnt_q + 4'd1;
            if (qualify && !is_blank) captured_d = 1'b1;
        end

        if (cap) begin
            val_d[{idx, 2'b00} +: 4] = dec[3:0];
            valid_d[idx]             = dec[4];

            if (idx == exp_q) begin
                case (exp_q)
                    EXP_D1: exp_d = EXP_D2;
                    EXP_D2: exp_d = EXP_D3;
                    EXP_D3: exp_d = EXP_D4;
                    default: begin
                        exp_d   = EXP_D1;
                        frame_d = 1'b1;
                    end
                endcase
            end else begin
                // A stray digit 1 is treated as the start of a new frame.
                seq_err = 1'b1;
                exp_d   = (idx == 2'd0) ? EXP_D2 : EXP_D1;
            end
        end

        // All error sources merge into a single pulse and a single increment.
        err_d     = multi_err || seq_err || (cap && !dec[4]);
        err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    assign VAL     = val_q;
    assign VALID   = valid_q;
    assign FRAME   = frame_q;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_seven_seg_monitor.sv
module tb_seven_seg_monitor;

    logic        CLK;
    logic        RST;
    logic        D1, D2, D3, D4;
    logic [6:0]  SEG;

    logic [15:0] val1, val3;
    logic [3:0]  valid1, valid3;
    logic        frame1, frame3, err1, err3;
    logic [7:0]  cnt1, cnt3;

    int checks = 0;
    int errors = 0;

    seven_seg_monitor #(.SETTLE(1)) dut1 (
        .CLK(CLK), .RST(RST), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .SEG(SEG),
        .VAL(val1), .VALID(valid1), .FRAME(frame1), .ERR(err1), .ERR_CNT(cnt1)
    );

    seven_seg_monitor #(.SETTLE(3)) dut3 (
        .CLK(CLK), .RST(RST), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .SEG(SEG),
        .VAL(val3), .VALID(valid3), .FRAME(frame3), .ERR(err3), .ERR_CNT(cnt3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] seg);
        {D4, D3, D2, D1} = en;
        SEG = seg;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(4'b0000, 7'h00);
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        drive(4'b0000, 7'h00);
        tick();
        tick();

        // Reset state
        check("rst_val", val1, 16'h0000);
        check("rst_valid", {12'h0, valid1}, 16'h0);
        check("rst_frame", {15'h0, frame1}, 16'h0);
        check("rst_err", {15'h0, err1}, 16'h0);
        check("rst_errcnt", {8'h0, cnt1}, 16'h0);
        check("rst_val3", val3, 16'h0000);
        RST = 1'b0;

        // T1: rotate digits one cycle each with SETTLE=1
        drive(4'b0001, 7'h06); tick();
        drive(4'b0010, 7'h5B); tick();
        drive(4'b0100, 7'h4F); tick();
        drive(4'b1000, 7'h66); tick();
        check("t1_frame_early", {15'h0, frame1}, 16'h0);
        check("t1_val_partial", val1, 16'h0321);
        drive(4'b0000, 7'h00); tick();
        check("t1_val", val1, 16'h4321);
        check("t1_valid", {12'h0, valid1}, 16'hF);
        check("t1_frame", {15'h0, frame1}, 16'h1);
        check("t1_err", {15'h0, err1}, 16'h0);
        tick();
        check("t1_frame_pulse", {15'h0, frame1}, 16'h0);
        check("t1_errcnt", {8'h0, cnt1}, 16'h0);

        // T2: SETTLE=3 needs three stable samples
        do_reset();
        drive(4'b0001, 7'h7F); tick(); tick();
        drive(4'b0000, 7'h00); tick();
        check("t2_short_val", val3, 16'h0000);
        check("t2_short_valid", {12'h0, valid3}, 16'h0);
        drive(4'b0001, 7'h7F); tick();
        tick();
        check("t2_edge2_val", val3, 16'h0000);
        tick();
        check("t2_edge3_pre", val3, 16'h0000);
        tick();
        check("t2_capture_val", val3, 16'h0008);
        check("t2_capture_valid", {12'h0, valid3}, 16'h1);
        check("t2_err", {8'h0, cnt3}, 16'h0);

        // T3: two enables together for 5 cycles -> one error
        do_reset();
        drive(4'b0101, 7'h06); tick();
        tick();
        check("t3_err_pulse", {15'h0, err1}, 16'h1);
        check("t3_errcnt1", {8'h0, cnt1}, 16'h1);
        tick(); tick(); tick();
        check("t3_err_low", {15'h0, err1}, 16'h0);
        check("t3_errcnt_hold", {8'h0, cnt1}, 16'h1);
        check("t3_val", val1, 16'h0000);
        check("t3_valid", {12'h0, valid1}, 16'h0);

        // T4: out-of-order D3, then a clean frame
        do_reset();
        drive(4'b0001, 7'h06); tick();
        drive(4'b0100, 7'h4F); tick();
        drive(4'b0000, 7'h00); tick();
        check("t4_seq_err", {15'h0, err1}, 16'h1);
        check("t4_no_frame", {15'h0, frame1}, 16'h0);
        check("t4_errcnt", {8'h0, cnt1}, 16'h1);
        drive(4'b0001, 7'h06); tick();
        drive(4'b0010, 7'h5B); tick();
        drive(4'b0100, 7'h4F); tick();
        drive(4'b1000, 7'h66); tick();
        drive(4'b0000, 7'h00); tick();
        check("t4_frame", {15'h0, frame1}, 16'h1);
        check("t4_err_clean", {15'h0, err1}, 16'h0);
        check("t4_val", val1, 16'h4321);
        check("t4_errcnt_after", {8'h0, cnt1}, 16'h1);

        // T5: illegal glyph on expected digit 2, then saturate the counter
        do_reset();
        drive(4'b0001, 7'h06); tick();
        drive(4'b0010, 7'h12); tick();
        drive(4'b0000, 7'h00); tick();
        check("t5_val", val1, 16'h0001);
        check("t5_valid", {12'h0, valid1}, 16'h1);
        check("t5_err", {15'h0, err1}, 16'h1);
        check("t5_errcnt1", {8'h0, cnt1}, 16'h1);
        for (int i = 2; i <= 300; i++) begin
            drive(4'b0010, 7'h12); tick();
            drive(4'b0000, 7'h00); tick();
            if (i == 254) check("t5_errcnt254", {8'h0, cnt1}, 16'd254);
        end
        check("t5_errcnt_sat", {8'h0, cnt1}, 16'd255);
        check("t5_val_bad", val1, 16'h0001);

        // T6: reset mid-frame, then frame restarts at digit 1
        do_reset();
        drive(4'b0001, 7'h06); tick();
        drive(4'b0010, 7'h5B); tick();
        drive(4'b0100, 7'h4F); tick();
        check("t6_mid_val", val1, 16'h0021);
        RST = 1'b1;
        tick();
        check("t6_rst_val", val1, 16'h0000);
        check("t6_rst_valid", {12'h0, valid1}, 16'h0);
        check("t6_rst_frame", {15'h0, frame1}, 16'h0);
        check("t6_rst_err", {15'h0, err1}, 16'h0);
        check("t6_rst_errcnt", {8'h0, cnt1}, 16'h0);
        RST = 1'b0;
        drive(4'b0001, 7'h77); tick();
        drive(4'b0010, 7'h7C); tick();
        drive(4'b0100, 7'h39); tick();
        drive(4'b1000, 7'h5E); tick();
        drive(4'b0000, 7'h00); tick();
        check("t6_frame", {15'h0, frame1}, 16'h1);
        check("t6_val", val1, 16'hDCBA);
        check("t6_errcnt", {8'h0, cnt1}, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
